// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode and phase encodings for the 8-bit RISC CPU.
//   Opcodes HLT..JMP (shared with the ALU), phases INST_ADDR..STORE,
//   and is_aluop() which flags opcodes that read memory into the accumulator.
package cpu_pkg;
   localparam logic [2:0] HLT = 3'b000;
   localparam logic [2:0] SKZ = 3'b001;
   localparam logic [2:0] ADD = 3'b010;
   localparam logic [2:0] AND = 3'b011;
   localparam logic [2:0] XOR = 3'b100;
   localparam logic [2:0] LDA = 3'b101;
   localparam logic [2:0] STO = 3'b110;
   localparam logic [2:0] JMP = 3'b111;
   localparam logic [2:0] INST_ADDR  = 3'd0;
   localparam logic [2:0] INST_FETCH = 3'd1;
   localparam logic [2:0] INST_LOAD  = 3'd2;
   localparam logic [2:0] IDLE       = 3'd3;
   localparam logic [2:0] OP_ADDR    = 3'd4;
   localparam logic [2:0] OP_FETCH   = 3'd5;
   localparam logic [2:0] ALU_OP     = 3'd6;
   localparam logic [2:0] STORE      = 3'd7;
   function automatic logic is_aluop(input logic [2:0] op);
      return op == ADD || op == AND || op == XOR || op == LDA;
   endfunction
endpackage

// File: rtl/risc_ctrl_decode.sv
// risc_ctrl_decode: combinational (phase, opcode, zero, halted) -> datapath strobes.
//   in : phase[2:0], opcode[2:0], zero, halted
//   out: sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt
//   Once halted, only halt stays asserted.
module risc_ctrl_decode
   import cpu_pkg::*;
(
   input  logic [2:0] phase,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       halted,
   output logic       sel,
   output logic       rd,
   output logic       wr,
   output logic       ld_ir,
   output logic       ld_ac,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       data_e,
   output logic       halt
);
   logic run, alu, exec;
   assign run    = !halted;
   assign alu    = is_aluop(opcode);
   assign exec   = phase == ALU_OP || phase == STORE;
   assign sel    = run && !phase[2];
   assign rd     = run && ((phase >= INST_FETCH && phase <= IDLE) || (phase >= OP_FETCH && alu));
   assign ld_ir  = run && (phase == INST_LOAD || phase == IDLE);
   assign inc_pc = run && (phase == OP_ADDR || (phase == ALU_OP && opcode == SKZ && zero));
   assign ld_pc  = run && exec && opcode == JMP;
   assign data_e = run && exec && opcode == STO;
   assign wr     = run && phase == STORE && opcode == STO;
   assign ld_ac  = run && phase == STORE && alu;
   assign halt   = halted || (phase == OP_ADDR && opcode == HLT);
endmodule

// File: rtl/risc_ctrl_seq.sv
// risc_ctrl_seq: eight-phase instruction sequencer for the 8-bit RISC CPU.
//   in : clk, rst_n (async, active-low), opcode[2:0], zero,
//        mem_ready (only when RISC_CTRL_WAIT_EN is defined)
//   out: phase[2:0], sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt
//   HALT_STICKY=1 freezes in phase 4 with halt=1 after HLT until reset.
//   Define RISC_CTRL_WAIT_EN to stretch phases 1 and 5 (aluop only) until mem_ready.
module risc_ctrl_seq
   import cpu_pkg::*;
#(
   parameter int HALT_STICKY = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic       zero,
`ifdef RISC_CTRL_WAIT_EN
   input  logic       mem_ready,
`endif
   output logic [2:0] phase,
   output logic       sel,
   output logic       rd,
   output logic       wr,
   output logic       ld_ir,
   output logic       ld_ac,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       data_e,
   output logic       halt
);
   logic [2:0] phase_nxt;
   logic       halted, halted_nxt, stall;
`ifdef RISC_CTRL_WAIT_EN
   assign stall = !mem_ready && (phase == INST_FETCH || (phase == OP_FETCH && is_aluop(opcode)));
`else
   assign stall = 1'b0;
`endif
   always_comb begin
      phase_nxt  = phase + 3'd1;
      halted_nxt = halted;
      if (halted || stall)
         phase_nxt = phase;
      else if (HALT_STICKY != 0 && phase == OP_ADDR && opcode == HLT) begin
         phase_nxt  = phase;
         halted_nxt = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         phase  <= INST_ADDR;
         halted <= 1'b0;
      end else begin
         phase  <= phase_nxt;
         halted <= halted_nxt;
      end
   risc_ctrl_decode u_dec (
      .phase (phase),
      .opcode(opcode),
      .zero  (zero),
      .halted(halted),
      .sel   (sel),
      .rd    (rd),
      .wr    (wr),
      .ld_ir (ld_ir),
      .ld_ac (ld_ac),
      .inc_pc(inc_pc),
      .ld_pc (ld_pc),
      .data_e(data_e),
      .halt  (halt)
   );
endmodule

// File: tb/tb_risc_ctrl_seq.sv
// tb_risc_ctrl_seq: directed bench for risc_ctrl_seq (HALT_STICKY=1).
//   Strobe vectors are {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt}.
module tb_risc_ctrl_seq;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] opcode = 3'b010;
   logic       zero = 1'b0;
`ifdef RISC_CTRL_WAIT_EN
   logic       mem_ready = 1'b1;
`endif
   logic [2:0] phase;
   logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
   int         checks = 0;
   int         failures = 0;

   risc_ctrl_seq #(.HALT_STICKY(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .opcode(opcode),
      .zero  (zero),
`ifdef RISC_CTRL_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .phase (phase),
      .sel   (sel),
      .rd    (rd),
      .wr    (wr),
      .ld_ir (ld_ir),
      .ld_ac (ld_ac),
      .inc_pc(inc_pc),
      .ld_pc (ld_pc),
      .data_e(data_e),
      .halt  (halt)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] obs();
      return {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};
   endfunction

   // hand-written expectations for phases 0..4 (no HLT)
   function automatic logic [8:0] fetch_exp(input int p);
      case (p)
         0: return 9'b100000000;
         1: return 9'b110000000;
         2: return 9'b110100000;
         3: return 9'b110100000;
         default: return 9'b000001000;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // checks phase number and strobes at the current sample point
   task automatic chk(input string name, input int p, input logic [8:0] e);
      checks++;
      if (phase !== 3'(p) || obs() !== e) begin
         failures++;
         $display("FAIL %s ph%0d: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                  name, p, phase, obs(), p, e);
      end
   endtask

   // runs one full instruction from phase 0, ending back at phase 0
   task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                            input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7);
      opcode = op;
      zero   = z;
      for (int p = 0; p < 5; p++) begin
         chk(name, p, fetch_exp(p));
         step();
      end
      chk(name, 5, e5);
      step();
      chk(name, 6, e6);
      step();
      chk(name, 7, e7);
      step();
      chk({name, "_wrap"}, 0, fetch_exp(0));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      chk("reset", 0, 9'b100000000);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_add();
      run_instr("add", 3'b010, 1'b0, 9'b010000000, 9'b010000000, 9'b010010000);
   endtask

   task automatic test_skz();
      run_instr("skz_z1", 3'b001, 1'b1, 9'b000000000, 9'b000001000, 9'b000000000);
      run_instr("skz_z0", 3'b001, 1'b0, 9'b000000000, 9'b000000000, 9'b000000000);
   endtask

   task automatic test_sto_jmp();
      run_instr("sto", 3'b110, 1'b0, 9'b000000000, 9'b000000010, 9'b001000010);
      run_instr("jmp", 3'b111, 1'b1, 9'b000000000, 9'b000000100, 9'b000000100);
      run_instr("lda", 3'b101, 1'b0, 9'b010000000, 9'b010000000, 9'b010010000);
      run_instr("xor", 3'b100, 1'b1, 9'b010000000, 9'b010000000, 9'b010010000);
   endtask

   task automatic test_halt();
      opcode = 3'b000;
      for (int p = 0; p < 4; p++) begin
         chk("hlt_fetch", p, fetch_exp(p));
         step();
      end
      chk("hlt_op_addr", 4, 9'b000001001);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("hlt_frozen", 4, 9'b000000001);
      end
      rst_n = 1'b0;
      #2;
      chk("hlt_reset", 0, 9'b100000000);
      rst_n = 1'b1;
      run_instr("after_hlt", 3'b010, 1'b0, 9'b010000000, 9'b010000000, 9'b010010000);
   endtask

   task automatic test_async_reset();
      opcode = 3'b111;
      for (int p = 0; p < 6; p++) step();
      chk("jmp_pre_rst", 6, 9'b000000100);
      rst_n = 1'b0;
      #1;
      chk("jmp_async_rst", 0, 9'b100000000);
      #1 rst_n = 1'b1;
      run_instr("jmp_restart", 3'b111, 1'b0, 9'b000000000, 9'b000000100, 9'b000000100);
   endtask

`ifdef RISC_CTRL_WAIT_EN
   task automatic test_wait();
      int cyc = 0, w1 = 0, w5 = 0, guard = 0;
      logic [8:0] e;
      opcode = 3'b101;
      zero   = 1'b0;
      do begin
         mem_ready = 1'b1;
         if (phase == 3'd1 && w1 < 3) begin mem_ready = 1'b0; w1++; end
         if (phase == 3'd5 && w5 < 2) begin mem_ready = 1'b0; w5++; end
         e = phase < 3'd5 ? fetch_exp(int'(phase)) : phase == 3'd7 ? 9'b010010000 : 9'b010000000;
         chk("wait_lda", int'(phase), e);
         step();
         cyc++;
         guard++;
      end while (phase != 3'd0 && guard < 40);
      mem_ready = 1'b1;
      checks++;
      if (cyc != 13) begin
         failures++;
         $display("FAIL wait_len: got %0d clocks, expected 13", cyc);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_skz();
      test_sto_jmp();
      test_halt();
      test_async_reset();
`ifdef RISC_CTRL_WAIT_EN
      test_wait();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
